// File: rtl/btn_cond_pkg.sv
// Shared definitions for the button/switch conditioner: edge-mode encoding
// and the helper that decides whether a debounced edge is reported.
package btn_cond_pkg;

   typedef logic [1:0] edge_mode_t;

   localparam edge_mode_t EDGE_NONE = 2'b00;
   localparam edge_mode_t EDGE_RISE = 2'b01;
   localparam edge_mode_t EDGE_FALL = 2'b10;
   localparam edge_mode_t EDGE_BOTH = 2'b11;

   function automatic logic edge_qualifies(input edge_mode_t mode,
                                           input logic       rise,
                                           input logic       fall);
      logic want_rise;
      logic want_fall;
      if (mode == EDGE_NONE) return 1'b0;
      want_rise = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
      want_fall = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
      return (rise && want_rise) || (fall && want_fall);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single-channel synchroniser, stable-count debouncer and level register.
// rise_o/fall_o are high in the cycle before level_o takes its new value.
module btn_debounce_ch #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 100,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic nrst,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int               CNT_W    = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   sync_bit;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_d   = '0;
      level_d = level_q;
      // Any cycle where the synchronised input agrees with the level restarts the count.
      if (sync_bit != level_q) begin
         if (cnt_q == CNT_LAST) level_d = sync_bit;
         else                   cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (!nrst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = (level_d != level_q) &&  sync_bit;
   assign fall_o  = (level_d != level_q) && !sync_bit;

endmodule

// File: rtl/btn_cond_irq.sv
// Multi-channel button/switch conditioner with per-channel edge selection,
// sticky pending flags and one maskable interrupt line.
module btn_cond_irq
   import btn_cond_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 100,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [NUM_CH-1:0]   raw_in,
   input  logic [2*NUM_CH-1:0] edge_mode,
   input  logic [NUM_CH-1:0]   irq_mask,
   input  logic [NUM_CH-1:0]   pend_clr,
   output logic [NUM_CH-1:0]   level_out,
   output logic [NUM_CH-1:0]   edge_pulse,
   output logic [NUM_CH-1:0]   pending,
   output logic                irq
);

   logic [NUM_CH-1:0] ch_rise, ch_fall;
   logic [NUM_CH-1:0] edge_pulse_q, edge_pulse_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic              irq_q, irq_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      btn_debounce_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES),
         .RESET_LEVEL (RESET_LEVEL)
      ) u_ch (
         .clk     (clk),
         .nrst    (nrst),
         .raw_i   (raw_in[i]),
         .level_o (level_out[i]),
         .rise_o  (ch_rise[i]),
         .fall_o  (ch_fall[i])
      );
   end

   always_comb begin
      edge_pulse_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         edge_pulse_d[i] = edge_qualifies(edge_mode[2*i +: 2], ch_rise[i], ch_fall[i]);
      end
      // Set wins over a simultaneous clear so no event is lost.
      pending_d = (pending_q & ~pend_clr) | edge_pulse_q;
      irq_d     = |(pending_q & irq_mask);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         edge_pulse_q <= '0;
         pending_q    <= '0;
         irq_q        <= 1'b0;
      end else begin
         edge_pulse_q <= edge_pulse_d;
         pending_q    <= pending_d;
         irq_q        <= irq_d;
      end
   end

   assign edge_pulse = edge_pulse_q;
   assign pending    = pending_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_btn_cond_irq.sv
// Directed bench for btn_cond_irq with default parameters: hand-computed
// vector table plus explicit reset and latency sequences.
module tb_btn_cond_irq;

   logic       clk = 1'b0;
   logic       nrst;
   logic [3:0] raw_in;
   logic [7:0] edge_mode;
   logic [3:0] irq_mask;
   logic [3:0] pend_clr;
   logic [3:0] level_out;
   logic [3:0] edge_pulse;
   logic [3:0] pending;
   logic       irq;

   btn_cond_irq #(
      .NUM_CH      (4),
      .SYNC_STAGES (2),
      .DB_CYCLES   (100),
      .RESET_LEVEL (1'b0)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .raw_in     (raw_in),
      .edge_mode  (edge_mode),
      .irq_mask   (irq_mask),
      .pend_clr   (pend_clr),
      .level_out  (level_out),
      .edge_pulse (edge_pulse),
      .pending    (pending),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic [3:0] raw;
      logic [7:0] mode;
      logic [3:0] mask;
      logic [3:0] clr;
      logic [3:0] lvl;
      logic [3:0] pls;
      logic [3:0] pnd;
      logic       irq;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // ch0 rise, ch1 rise, ch2 both, ch3 rise
   localparam logic [7:0] M = 8'h75;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [3:0] lvl, input logic [3:0] pls,
                        input logic [3:0] pnd, input logic irq_exp);
      n_vec++;
      if ({level_out, edge_pulse, pending, irq} !== {lvl, pls, pnd, irq_exp}) begin
         n_fail++;
         $display("FAIL %s: got lvl=%h pls=%h pnd=%h irq=%b, want lvl=%h pls=%h pnd=%h irq=%b",
                  name, level_out, edge_pulse, pending, irq, lvl, pls, pnd, irq_exp);
      end
   endtask

   task automatic add(input int n, input logic [3:0] raw, input logic [7:0] mode,
                      input logic [3:0] mask, input logic [3:0] clr, input logic [3:0] lvl,
                      input logic [3:0] pls, input logic [3:0] pnd, input logic irq_exp);
      vec_t v;
      v.n = n; v.raw = raw; v.mode = mode; v.mask = mask; v.clr = clr;
      v.lvl = lvl; v.pls = pls; v.pnd = pnd; v.irq = irq_exp;
      vecs.push_back(v);
   endtask

   initial begin
      // Reset held with all inputs high: nothing may move.
      nrst = 1'b0; raw_in = 4'hF; edge_mode = 8'h55; irq_mask = 4'h0; pend_clr = 4'h0;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         check($sformatf("reset_c%0d", c), 4'h0, 4'h0, 4'h0, 1'b0);
      end
      nrst = 1'b1;
      tick(101); check("post_reset_hold",    4'h0, 4'h0, 4'h0, 1'b0);
      tick(1);   check("post_reset_edge",    4'hF, 4'hF, 4'h0, 1'b0);
      tick(1);   check("post_reset_pending", 4'hF, 4'h0, 4'hF, 1'b0);
      pend_clr = 4'hF;
      tick(1);   check("post_reset_clear",   4'hF, 4'h0, 4'h0, 1'b0);
      pend_clr = 4'h0;

      //   n    raw   mode   mask  clr   lvl   pls   pnd   irq
      // Return all channels low with mode none: no pulses.
      add(101, 4'h0, 8'h00, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
      add(1,   4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      // ch0 rising edge, masked in; release gives no pulse.
      add(101, 4'h1, M,     4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      add(1,   4'h1, M,     4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0);
      add(1,   4'h1, M,     4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0);
      add(1,   4'h1, M,     4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1);
      add(106, 4'h1, M,     4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1);
      add(101, 4'h0, M,     4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1);
      add(1,   4'h0, M,     4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1);
      add(3,   4'h0, M,     4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1);
      add(1,   4'h0, M,     4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
      add(1,   4'h0, M,     4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      // ch1 99-cycle glitch never reaches the level.
      add(99,  4'h2, M,     4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      add(110, 4'h0, M,     4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      // ch2 toggling every 10 cycles, then held high.
      for (int t = 0; t < 8; t++)
         add(10, (t % 2 == 0) ? 4'h4 : 4'h0, M, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      add(101, 4'h4, M,     4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      add(1,   4'h4, M,     4'h5, 4'h0, 4'h4, 4'h4, 4'h0, 1'b0);
      add(1,   4'h4, M,     4'h5, 4'h0, 4'h4, 4'h0, 4'h4, 1'b0);
      add(1,   4'h4, M,     4'h5, 4'h0, 4'h4, 4'h0, 4'h4, 1'b1);
      add(1,   4'h4, M,     4'h5, 4'h4, 4'h4, 4'h0, 4'h0, 1'b1);
      add(1,   4'h4, M,     4'h5, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0);
      // ch2 falling edge with pend_clr in the pulse cycle: set wins.
      add(101, 4'h0, M,     4'h5, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0);
      add(1,   4'h0, M,     4'h5, 4'h0, 4'h0, 4'h4, 4'h0, 1'b0);
      add(1,   4'h0, M,     4'h5, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0);
      add(1,   4'h0, M,     4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 1'b1);
      add(5,   4'h0, M,     4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 1'b1);
      add(1,   4'h0, M,     4'h5, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1);
      add(1,   4'h0, M,     4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      // ch3 pending while masked, then mask toggled.
      add(101, 4'h8, M,     4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      add(1,   4'h8, M,     4'h5, 4'h0, 4'h8, 4'h8, 4'h0, 1'b0);
      add(1,   4'h8, M,     4'h5, 4'h0, 4'h8, 4'h0, 4'h8, 1'b0);
      add(3,   4'h8, M,     4'h5, 4'h0, 4'h8, 4'h0, 4'h8, 1'b0);
      add(1,   4'h8, M,     4'hD, 4'h0, 4'h8, 4'h0, 4'h8, 1'b1);
      add(1,   4'h8, M,     4'h5, 4'h0, 4'h8, 4'h0, 4'h8, 1'b0);
      add(1,   4'h8, M,     4'hD, 4'h0, 4'h8, 4'h0, 4'h8, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         raw_in    = vecs[i].raw;
         edge_mode = vecs[i].mode;
         irq_mask  = vecs[i].mask;
         pend_clr  = vecs[i].clr;
         tick(vecs[i].n);
         check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].pls, vecs[i].pnd, vecs[i].irq);
      end
      pend_clr = 4'h0;

      // Reset partway through a ch0 debounce discards the partial count.
      raw_in = 4'h9;
      tick(50);  check("mid_debounce",      4'h8, 4'h0, 4'h8, 1'b1);
      nrst = 1'b0;
      tick(1);   check("mid_reset",         4'h0, 4'h0, 4'h0, 1'b0);
      nrst = 1'b1;
      tick(101); check("mid_release_hold",  4'h0, 4'h0, 4'h0, 1'b0);
      tick(1);   check("mid_release_edge",  4'h9, 4'h9, 4'h0, 1'b0);
      tick(1);   check("mid_release_pend",  4'h9, 4'h0, 4'h9, 1'b0);
      tick(1);   check("mid_release_irq",   4'h9, 4'h0, 4'h9, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
